// File: rtl/coeff_mem_ctrl.sv
// Coefficient memory sequencer: owns every control pin of the single-port,
// registered-read coefficient RAM. Bulk-loads a host stream into addresses
// 0..WORDS-1, then scans the full set out to the classifier on request.
module coeff_mem_ctrl #(
  parameter int DEPTH = 24,
  parameter int WORDS = 5,
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             wr_valid,
  input  logic [DEPTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             load_done,
  output logic             coef_valid,
  input  logic             scan_start,
  output logic             scan_err,
  output logic             rd_valid,
  output logic [DEPTH-1:0] rd_data,
  output logic [AW-1:0]    rd_index,
  output logic             rd_last,
  output logic             busy,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DEPTH-1:0] mem_d,
  input  logic [DEPTH-1:0] mem_q
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN} state_t;

  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  // High in the cycle a scan address sits on mem_a; its data shows up next cycle.
  logic          r_iss;

  logic w_cnt_last;
  logic w_idle_free;

  assign w_cnt_last  = (r_cnt == LAST);
  assign busy        = (r_state != S_IDLE) || r_iss || rd_valid;
  assign w_idle_free = (r_state == S_IDLE) && !busy;
  assign wr_ready    = (r_state == S_LOAD);
  // Memory q is only meaningful alongside rd_valid; keep the bus quiet otherwise.
  assign rd_data     = rd_valid ? mem_q : '0;

  // Control FSM: start arbitration, load address/data capture, scan address issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_iss      <= 1'b0;
      coef_valid <= 1'b0;
      load_done  <= 1'b0;
      scan_err   <= 1'b0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= '0;
      mem_d      <= '0;
    end else begin
      load_done <= 1'b0;
      scan_err  <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      r_iss     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Starts are only honoured once the read pipeline has drained.
          // Load beats scan; a simultaneous scan is dropped without error.
          if (w_idle_free) begin
            if (load_start) begin
              r_state    <= S_LOAD;
              r_cnt      <= '0;
              coef_valid <= 1'b0;
            end else if (scan_start) begin
              if (coef_valid) begin
                r_state <= S_SCAN;
                r_cnt   <= '0;
              end else begin
                scan_err <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          // wr_ready is the state itself, so wr_valid alone marks an accept.
          if (wr_valid) begin
            mem_ce <= 1'b1;
            mem_we <= 1'b1;
            mem_a  <= r_cnt;
            mem_d  <= wr_data;
            if (w_cnt_last) begin
              r_state    <= S_IDLE;
              r_cnt      <= '0;
              coef_valid <= 1'b1;
              load_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + AW'(1);
            end
          end
        end
        S_SCAN: begin
          // One address per cycle; the terminal count exits so no wrap occurs.
          mem_a <= r_cnt;
          r_iss <= 1'b1;
          if (w_cnt_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + AW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read return stage: tag the word coming back from memory with its address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_index <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= r_iss;
      rd_index <= r_iss ? mem_a : '0;
      rd_last  <= r_iss && (mem_a == LAST);
    end
  end

endmodule

// File: tb/tb_coeff_mem_ctrl.sv
// Directed bench for coeff_mem_ctrl with a behavioural registered-read RAM.
module tb_coeff_mem_ctrl;

  localparam int DEPTH = 24;
  localparam int WORDS = 5;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_start, wr_valid, scan_start;
  logic [DEPTH-1:0] wr_data;
  logic             wr_ready, load_done, coef_valid, scan_err;
  logic             rd_valid, rd_last, busy, mem_ce, mem_we;
  logic [DEPTH-1:0] rd_data, mem_d, mem_q;
  logic [AW-1:0]    rd_index, mem_a;

  int n_vec = 0;
  int n_err = 0;
  int n_scan_err = 0;
  int n_load_done = 0;

  typedef struct packed { logic [AW-1:0] idx; logic [DEPTH-1:0] d; logic last; } rd_t;
  typedef struct packed { logic [AW-1:0] a; logic [DEPTH-1:0] d; } wr_t;
  rd_t rdq[$];
  wr_t wq[$];
  logic [DEPTH-1:0] mem [0:7];

  coeff_mem_ctrl #(.DEPTH(DEPTH), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .load_done(load_done),
    .coef_valid(coef_valid), .scan_start(scan_start), .scan_err(scan_err),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_index(rd_index), .rd_last(rd_last),
    .busy(busy), .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a), .mem_d(mem_d),
    .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Registered-read RAM model; logs every write.
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem_q = '0;
  end
  always @(posedge clk) begin
    if (mem_ce && mem_we) begin
      mem[mem_a] <= mem_d;
      wq.push_back({mem_a, mem_d});
    end else if (!mem_we) begin
      mem_q <= mem[mem_a];
    end
  end

  // Output monitors sampled mid-cycle.
  always @(negedge clk) begin
    if (rd_valid) rdq.push_back({rd_index, rd_data, rd_last});
    if (scan_err) n_scan_err++;
    if (load_done) n_load_done++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [DEPTH-1:0] word(input int i, input bit alt);
    logic [DEPTH-1:0] w;
    w = alt ? (24'hA00000 + DEPTH'(i)) : DEPTH'(24'h111111 * (i + 1));
    return w;
  endfunction

  // Feeds WORDS words back to back; returns in the cycle after the last accept.
  task automatic feed_words(input bit alt);
    for (int i = 0; i < WORDS; i++) begin
      wr_valid = 1'b1; wr_data = word(i, alt);
      step();
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 0; scan_start = 0; wr_valid = 0; wr_data = '0;
    repeat (3) step();
    n_vec++;
    if ({wr_ready, load_done, coef_valid, scan_err, rd_valid, rd_last, busy, mem_ce, mem_we} !== 9'b0) begin
      $display("FAIL reset_flags got=%b exp=0", {wr_ready, load_done, coef_valid, scan_err, rd_valid, rd_last, busy, mem_ce, mem_we}); n_err++;
    end
    n_vec++;
    if ({rd_data, rd_index, mem_a, mem_d} !== '0) begin
      $display("FAIL reset_buses got=%h exp=0", {rd_data, rd_index, mem_a, mem_d}); n_err++;
    end
    reset = 1'b0;
    step();
    n_scan_err = 0; rdq.delete();
    scan_start = 1'b1; step(); scan_start = 1'b0;
    n_vec++;
    if (scan_err !== 1'b1) begin $display("FAIL reset_scan_err got=%b exp=1", scan_err); n_err++; end
    step();
    n_vec++;
    if (scan_err !== 1'b0) begin $display("FAIL reset_scan_err_pulse got=%b exp=0", scan_err); n_err++; end
    repeat (5) step();
    n_vec++;
    if (rdq.size() != 0 || n_scan_err != 1) begin
      $display("FAIL reset_scan_out rd=%0d err_pulses=%0d exp 0/1", rdq.size(), n_scan_err); n_err++;
    end
    n_vec++;
    if (coef_valid !== 1'b0) begin $display("FAIL reset_coef_valid got=%b exp=0", coef_valid); n_err++; end
  endtask

  task automatic test_load();
    wq.delete(); n_load_done = 0;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      if (i == 3) begin wr_valid = 1'b0; repeat (2) step(); end
      n_vec++;
      if (wr_ready !== 1'b1) begin $display("FAIL load_ready w%0d got=%b exp=1", i, wr_ready); n_err++; end
      wr_valid = 1'b1; wr_data = word(i, 1'b0);
      step();
    end
    wr_valid = 1'b0;
    n_vec++;
    if ({wr_ready, load_done, coef_valid} !== 3'b011) begin
      $display("FAIL load_end ready/done/valid got=%b exp=011", {wr_ready, load_done, coef_valid}); n_err++;
    end
    step(); step();
    n_vec++;
    if (load_done !== 1'b0 || n_load_done != 1) begin
      $display("FAIL load_done_pulse got=%b count=%0d exp 0/1", load_done, n_load_done); n_err++;
    end
    n_vec++;
    if (wq.size() != WORDS) begin $display("FAIL load_wr_count got=%0d exp=%0d", wq.size(), WORDS); n_err++; end
    for (int i = 0; i < WORDS && i < wq.size(); i++) begin
      n_vec++;
      if (wq[i] !== {AW'(i), word(i, 1'b0)}) begin
        $display("FAIL load_wr%0d got=%h exp=%h", i, wq[i], {AW'(i), word(i, 1'b0)}); n_err++;
      end
    end
  endtask

  task automatic test_scan();
    rdq.delete();
    scan_start = 1'b1; step(); scan_start = 1'b0;
    n_vec++;
    if ({rd_valid, busy} !== 2'b01) begin $display("FAIL scan_c1 valid/busy got=%b exp=01", {rd_valid, busy}); n_err++; end
    step();
    n_vec++;
    if (rd_valid !== 1'b0) begin $display("FAIL scan_c2 rd_valid got=%b exp=0", rd_valid); n_err++; end
    step();
    for (int i = 0; i < WORDS; i++) begin
      n_vec++;
      if ({rd_valid, busy, rd_index, rd_data, rd_last} !== {2'b11, AW'(i), word(i, 1'b0), i == WORDS - 1}) begin
        $display("FAIL scan_rd%0d got v=%b b=%b i=%0d d=%h l=%b exp i=%0d d=%h", i, rd_valid, busy,
                 rd_index, rd_data, rd_last, i, word(i, 1'b0)); n_err++;
      end
      step();
    end
    n_vec++;
    if ({rd_valid, busy} !== 2'b00) begin $display("FAIL scan_end valid/busy got=%b exp=00", {rd_valid, busy}); n_err++; end
  endtask

  task automatic test_back_to_back();
    rdq.delete();
    load_start = 1'b1; step(); load_start = 1'b0;
    feed_words(1'b1);
    n_vec++;
    if (load_done !== 1'b1) begin $display("FAIL b2b_load_done got=%b exp=1", load_done); n_err++; end
    scan_start = 1'b1; step(); scan_start = 1'b0;
    repeat (9) step();
    n_vec++;
    if (rdq.size() != WORDS) begin $display("FAIL b2b_count got=%0d exp=%0d", rdq.size(), WORDS); n_err++; end
    for (int i = 0; i < WORDS && i < rdq.size(); i++) begin
      n_vec++;
      if (rdq[i] !== {AW'(i), word(i, 1'b1), i == WORDS - 1}) begin
        $display("FAIL b2b_rd%0d got=%h exp=%h", i, rdq[i], {AW'(i), word(i, 1'b1), i == WORDS - 1}); n_err++;
      end
    end
  endtask

  task automatic test_load_beats_scan();
    rdq.delete(); n_scan_err = 0;
    load_start = 1'b1; scan_start = 1'b1; step(); load_start = 1'b0; scan_start = 1'b0;
    n_vec++;
    if ({wr_ready, coef_valid, scan_err} !== 3'b100) begin
      $display("FAIL collide ready/valid/err got=%b exp=100", {wr_ready, coef_valid, scan_err}); n_err++;
    end
    repeat (4) step();
    n_vec++;
    if (rdq.size() != 0 || n_scan_err != 0) begin
      $display("FAIL collide_scan rd=%0d err=%0d exp 0/0", rdq.size(), n_scan_err); n_err++;
    end
    feed_words(1'b0);
    step();
    n_vec++;
    if (coef_valid !== 1'b1) begin $display("FAIL collide_reload coef_valid got=%b exp=1", coef_valid); n_err++; end
  endtask

  task automatic test_starts_ignored();
    rdq.delete(); n_scan_err = 0;
    scan_start = 1'b1; step();
    // Hold both starts through every busy cycle, including the rd_last cycle.
    load_start = 1'b1;
    repeat (7) step();
    load_start = 1'b0; scan_start = 1'b0;
    n_vec++;
    if ({wr_ready, busy} !== 2'b00) begin $display("FAIL ignore_state ready/busy got=%b exp=00", {wr_ready, busy}); n_err++; end
    repeat (4) step();
    n_vec++;
    if (rdq.size() != WORDS || n_scan_err != 0 || coef_valid !== 1'b1) begin
      $display("FAIL ignore_run rd=%0d err=%0d valid=%b exp %0d/0/1", rdq.size(), n_scan_err, coef_valid, WORDS); n_err++;
    end
    for (int i = 0; i < WORDS && i < rdq.size(); i++) begin
      n_vec++;
      if (rdq[i] !== {AW'(i), word(i, 1'b0), i == WORDS - 1}) begin
        $display("FAIL ignore_rd%0d got=%h exp=%h", i, rdq[i], {AW'(i), word(i, 1'b0), i == WORDS - 1}); n_err++;
      end
    end
  endtask

  task automatic test_reset_mid_load();
    rdq.delete(); n_scan_err = 0;
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = word(i, 1'b1); step();
    end
    wr_valid = 1'b0;
    reset = 1'b1; #1;
    n_vec++;
    if ({wr_ready, coef_valid, busy, mem_ce, mem_we, load_done} !== 6'b0 || mem_a !== '0 || mem_d !== '0) begin
      $display("FAIL midload_reset flags=%b a=%0d d=%h exp all 0", {wr_ready, coef_valid, busy, mem_ce, mem_we, load_done}, mem_a, mem_d); n_err++;
    end
    step(); reset = 1'b0; step();
    scan_start = 1'b1; step(); scan_start = 1'b0;
    n_vec++;
    if ({scan_err, coef_valid} !== 2'b10) begin
      $display("FAIL midload_scan err/valid got=%b exp=10", {scan_err, coef_valid}); n_err++;
    end
    repeat (6) step();
    n_vec++;
    if (rdq.size() != 0 || n_scan_err != 1) begin
      $display("FAIL midload_out rd=%0d err=%0d exp 0/1", rdq.size(), n_scan_err); n_err++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_scan();
    test_back_to_back();
    test_load_beats_scan();
    test_starts_ignored();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
